// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - DIFT tag-path constants, load-mode encodings and load-tag FSM states
package riscv_defines;

   // Tag Propagation Register: load-side fields
   localparam int LOAD_EN_ADDR  = 10;
   localparam int LOAD_EN_DATA  = 11;
   localparam int LOAD_MODE_LSB = 12;
   localparam int LOAD_MODE_MSB = 13;

   // Tag Check Register: trap on loads through a tainted address
   localparam int TCR_LOAD_ADDR_CHK = 4;

   // LSU access size encodings
   localparam logic [1:0] DATA_TYPE_BYTE = 2'b00;
   localparam logic [1:0] DATA_TYPE_HALF = 2'b01;
   localparam logic [1:0] DATA_TYPE_WORD = 2'b10;

   typedef enum logic [1:0] {
      LOAD_MODE_DATA = 2'b00,
      LOAD_MODE_OR   = 2'b01,
      LOAD_MODE_AND  = 2'b10,
      LOAD_MODE_ZERO = 2'b11
   } load_mode_e;

   typedef enum logic [1:0] {
      LT_IDLE        = 2'b00,
      LT_WAIT_GNT    = 2'b01,
      LT_WAIT_RVALID = 2'b10
   } load_tag_state_e;

endpackage

// File: rtl/riscv_tag_byte_merge.sv
// rtl/riscv_tag_byte_merge.sv - OR-reduction of the byte tags touched by a byte/half/word access
module riscv_tag_byte_merge
   import riscv_defines::*;
#(
   parameter int TAG_W = 1
) (
   input  logic [1:0]         data_type_i,
   input  logic [1:0]         addr_off_i,
   input  logic [4*TAG_W-1:0] byte_tag_i,
   output logic [TAG_W-1:0]   tag_o
);

   logic [3:0] byte_sel;

   // Accessed-byte mask; misaligned halves and unaligned words keep only the in-word bytes
   // because the LSU splits the access and the other half carries the remaining bytes.
   always_comb begin
      byte_sel = 4'b0000;
      case (data_type_i)
         DATA_TYPE_BYTE: byte_sel = 4'b0001 << addr_off_i;
         DATA_TYPE_HALF: byte_sel = (addr_off_i == 2'd3) ? 4'b1000 : (4'b0011 << addr_off_i);
         default:        byte_sel = 4'b1111 << addr_off_i;
      endcase
   end

   // OR together the tags of the selected bytes
   always_comb begin
      tag_o = '0;
      for (int k = 0; k < 4; k++) begin
         if (byte_sel[k]) begin
            tag_o = tag_o | byte_tag_i[k*TAG_W +: TAG_W];
         end
      end
   end

endmodule

// File: rtl/riscv_load_tag_propagate.sv
// rtl/riscv_load_tag_propagate.sv - load-side DIFT tag tracker; DIFT_LOAD_ADDR_CHECK_EN adds the tainted-address load check
module riscv_load_tag_propagate
   import riscv_defines::*;
#(
   parameter int TAG_W = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          tpr_i,
   input  logic                 data_req_ex_i,
   input  logic                 data_we_ex_i,
   input  logic [1:0]           data_type_ex_i,
   input  logic [1:0]           data_addr_off_i,
   input  logic [TAG_W-1:0]     tag_addr_i,
   input  logic                 data_gnt_i,
   input  logic                 data_rvalid_i,
   input  logic [4*TAG_W-1:0]   data_rtag_i,
   input  logic [31:0]          tcr_i,
   output logic [TAG_W-1:0]     tag_wb_o,
   output logic                 tag_wb_valid_o,
   output logic                 tag_exc_o,
   output logic                 busy_o
);

   load_tag_state_e  state_q, state_d;
   logic             en_addr_q, en_addr_d;
   logic             en_data_q, en_data_d;
   load_mode_e       mode_q, mode_d;
   logic [TAG_W-1:0] tag_addr_q, tag_addr_d;
   logic [1:0]       type_q, type_d;
   logic [1:0]       off_q, off_d;
   logic [TAG_W-1:0] tag_wb_q, tag_wb_d;
   logic             valid_q, valid_d;

   logic             load_req;
   logic             capture;
   logic [TAG_W-1:0] mtag;
   logic [TAG_W-1:0] a_tag;
   logic [TAG_W-1:0] m_tag;
   logic [TAG_W-1:0] result;

   logic unused_tpr;
   assign unused_tpr = ^{tpr_i[31:LOAD_MODE_MSB+1], tpr_i[LOAD_EN_ADDR-1:0]};

   assign load_req = data_req_ex_i & ~data_we_ex_i;

   riscv_tag_byte_merge #(.TAG_W(TAG_W)) u_byte_merge (
      .data_type_i (type_q),
      .addr_off_i  (off_q),
      .byte_tag_i  (data_rtag_i),
      .tag_o       (mtag)
   );

   // Combine the gated address and memory tags under the snapshotted load mode
   always_comb begin
      a_tag  = tag_addr_q & {TAG_W{en_addr_q}};
      m_tag  = mtag & {TAG_W{en_data_q}};
      result = '0;
      case (mode_q)
         LOAD_MODE_DATA: result = m_tag;
         LOAD_MODE_OR:   result = a_tag | m_tag;
         LOAD_MODE_AND:  result = a_tag & m_tag;
         default:        result = '0;
      endcase
   end

   // Handshake FSM: one load in flight, back-to-back recapture on rvalid
   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      tag_wb_d = tag_wb_q;
      capture = 1'b0;
      case (state_q)
         LT_IDLE: begin
            if (load_req) begin
               capture = 1'b1;
               state_d = data_gnt_i ? LT_WAIT_RVALID : LT_WAIT_GNT;
            end
         end
         LT_WAIT_GNT: begin
            if (data_gnt_i) begin
               state_d = LT_WAIT_RVALID;
            end
         end
         LT_WAIT_RVALID: begin
            if (data_rvalid_i) begin
               valid_d  = 1'b1;
               tag_wb_d = result;
               if (load_req) begin
                  capture = 1'b1;
                  state_d = data_gnt_i ? LT_WAIT_RVALID : LT_WAIT_GNT;
               end else begin
                  state_d = LT_IDLE;
               end
            end
         end
         default: state_d = LT_IDLE;
      endcase
   end

   // Snapshot the request-side fields when a load is accepted into the tracker
   always_comb begin
      en_addr_d  = en_addr_q;
      en_data_d  = en_data_q;
      mode_d     = mode_q;
      tag_addr_d = tag_addr_q;
      type_d     = type_q;
      off_d      = off_q;
      if (capture) begin
         en_addr_d  = tpr_i[LOAD_EN_ADDR];
         en_data_d  = tpr_i[LOAD_EN_DATA];
         mode_d     = load_mode_e'(tpr_i[LOAD_MODE_MSB:LOAD_MODE_LSB]);
         tag_addr_d = tag_addr_i;
         type_d     = data_type_ex_i;
         off_d      = data_addr_off_i;
      end
   end

   // State and capture registers; reset wins over everything, dropping any pending pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LT_IDLE;
         en_addr_q  <= 1'b0;
         en_data_q  <= 1'b0;
         mode_q     <= LOAD_MODE_DATA;
         tag_addr_q <= '0;
         type_q     <= 2'b00;
         off_q      <= 2'b00;
         tag_wb_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_addr_q  <= en_addr_d;
         en_data_q  <= en_data_d;
         mode_q     <= mode_d;
         tag_addr_q <= tag_addr_d;
         type_q     <= type_d;
         off_q      <= off_d;
         tag_wb_q   <= tag_wb_d;
         valid_q    <= valid_d;
      end
   end

`ifdef DIFT_LOAD_ADDR_CHECK_EN
   logic chk_q, chk_d;
   logic exc_q, exc_d;
   logic unused_tcr;
   assign unused_tcr = ^{tcr_i[31:TCR_LOAD_ADDR_CHK+1], tcr_i[TCR_LOAD_ADDR_CHK-1:0]};

   // Address-taint check decided at request time, reported alongside the writeback pulse
   always_comb begin
      chk_d = capture ? (tcr_i[TCR_LOAD_ADDR_CHK] & (|tag_addr_i)) : chk_q;
      exc_d = valid_d & chk_q;
   end

   // Check flag and exception registers
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_q <= 1'b0;
         exc_q <= 1'b0;
      end else begin
         chk_q <= chk_d;
         exc_q <= exc_d;
      end
   end

   assign tag_exc_o = exc_q;
`else
   logic unused_tcr;
   assign unused_tcr = ^tcr_i;
   assign tag_exc_o  = 1'b0;
`endif

   assign tag_wb_o       = tag_wb_q;
   assign tag_wb_valid_o = valid_q;
   assign busy_o         = (state_q != LT_IDLE);

endmodule
